// File: rtl/seven_seg_scan_ctrl_if.sv
// Load port of the seven-segment scan controller.
// Value, masks and zero-suppress flag travel with a valid/ready pair.
interface seven_seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 8
);
   logic                    load_valid;
   logic                    load_ready;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    lz_suppress;

   modport master (
      output load_valid,
      output value,
      output dp_mask,
      output blank_mask,
      output lz_suppress,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  value,
      input  dp_mask,
      input  blank_mask,
      input  lz_suppress,
      output load_ready
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display.
// Loads are double-buffered and only reach the display at frame ends.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 100000,
   parameter int GUARD_CYCLES = 2000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   seven_seg_scan_ctrl_if.slave  ld,
   output logic [3:0]            digit_num,
   output logic                  digit_dp,
   output logic [NUM_DIGITS-1:0] anode,
   output logic                  frame_done
);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(DIGIT_CYCLES);
   localparam int VW = 4 * NUM_DIGITS;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] GUARD    = CW'(GUARD_CYCLES);

   logic [VW-1:0]         pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
   logic                  pend_lz_q, pend_lz_d;
   logic                  pend_full_q, pend_full_d;
   logic [VW-1:0]         act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
   logic                  act_lz_q, act_lz_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  run_q, run_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [3:0]            num_q, num_d;
   logic                  dp_q, dp_d;
   logic                  fd_q, fd_d;

   logic take;
   logic commit;
   logic dark;
   int   msd;

   always_comb begin
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pend_lz_d    = pend_lz_q;
      pend_full_d  = pend_full_q;
      act_val_d    = act_val_q;
      act_dp_d     = act_dp_q;
      act_blank_d  = act_blank_q;
      act_lz_d     = act_lz_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      run_d        = run_q;
      anode_d      = '1;
      num_d        = 4'h0;
      dp_d         = 1'b0;
      fd_d         = 1'b0;
      msd          = 0;
      dark         = 1'b0;

      take   = ld.load_valid && !pend_full_q;
      commit = pend_full_q && (fd_q || !en);

      if (take) begin
         pend_val_d   = ld.value;
         pend_dp_d    = ld.dp_mask;
         pend_blank_d = ld.blank_mask;
         pend_lz_d    = ld.lz_suppress;
         pend_full_d  = 1'b1;
      end
      if (commit) begin
         act_val_d   = pend_val_q;
         act_dp_d    = pend_dp_q;
         act_blank_d = pend_blank_q;
         act_lz_d    = pend_lz_q;
         pend_full_d = 1'b0;
      end

      // First enabled cycle after a park always lands on slot 0, guard first
      if (!en) begin
         run_d = 1'b0;
         idx_d = '0;
         cnt_d = '0;
      end else if (!run_q) begin
         run_d = 1'b1;
         idx_d = '0;
         cnt_d = '0;
      end else if (cnt_q == LAST_CNT) begin
         cnt_d = '0;
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (act_val_d[4*i +: 4] != 4'h0) msd = i;
      end
      dark = act_blank_d[idx_d] ||
             (act_lz_d && (int'(idx_d) > msd));

      // Outputs follow the next position and next active value
      if (en) begin
         if (!dark) begin
            num_d = act_val_d[4*idx_d +: 4];
            dp_d  = act_dp_d[idx_d];
            if (cnt_d >= GUARD)
               anode_d = ~(NUM_DIGITS'(1) << idx_d);
         end
         fd_d = (idx_d == LAST_IDX) && (cnt_d == LAST_CNT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         pend_lz_q    <= 1'b0;
         pend_full_q  <= 1'b0;
         act_val_q    <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '0;
         act_lz_q     <= 1'b0;
         idx_q        <= '0;
         cnt_q        <= '0;
         run_q        <= 1'b0;
         anode_q      <= '1;
         num_q        <= 4'h0;
         dp_q         <= 1'b0;
         fd_q         <= 1'b0;
      end else begin
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         pend_lz_q    <= pend_lz_d;
         pend_full_q  <= pend_full_d;
         act_val_q    <= act_val_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         act_lz_q     <= act_lz_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         run_q        <= run_d;
         anode_q      <= anode_d;
         num_q        <= num_d;
         dp_q         <= dp_d;
         fd_q         <= fd_d;
      end
   end

   assign ld.load_ready = !pend_full_q;
   assign anode         = anode_q;
   assign digit_num     = num_q;
   assign digit_dp      = dp_q;
   assign frame_done    = fd_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a per-cycle scoreboard.
// Expected frames are queued when loads are made, popped each clock.
module tb_seven_seg_scan_ctrl;
   localparam int ND = 8;
   localparam int DC = 4;
   localparam int GC = 1;
   localparam int FR = ND * DC;

   logic       clk     = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst_n   = 1'b1;
   logic       en      = 1'b0;
   logic [3:0] digit_num;
   logic       digit_dp;
   logic [7:0] anode;
   logic       frame_done;

   int tests = 0;
   int fails = 0;
   logic [13:0] sb[$];

   logic [31:0] cur_val   = '0;
   logic [7:0]  cur_dp    = '0;
   logic [7:0]  cur_blank = '0;
   logic        cur_lz    = 1'b0;

   seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) ld ();

   seven_seg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .DIGIT_CYCLES(DC),
      .GUARD_CYCLES(GC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .ld        (ld.slave),
      .digit_num (digit_num),
      .digit_dp  (digit_dp),
      .anode     (anode),
      .frame_done(frame_done)
   );

   always #5 clk = clk_run ? ~clk : clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Model of one frame: {anode, digit_num, digit_dp, frame_done}
   task automatic push_frame(input logic [31:0] v,
                             input logic [7:0] dp,
                             input logic [7:0] bl,
                             input logic lz);
      int top;
      top = 0;
      for (int i = ND - 1; i >= 0; i--) begin
         if (v[4*i +: 4] != 4'h0) begin
            top = i;
            break;
         end
      end
      for (int c = 0; c < FR; c++) begin
         int   s;
         int   ph;
         logic drk;
         logic [7:0] a;
         logic [3:0] n;
         logic d;
         s   = c / DC;
         ph  = c % DC;
         drk = bl[s] || (lz && s > top);
         a   = 8'hFF;
         n   = drk ? 4'h0 : v[4*s +: 4];
         d   = drk ? 1'b0 : dp[s];
         if (!drk && ph >= GC) a[s] = 1'b0;
         sb.push_back({a, n, d, (c == FR - 1)});
      end
   endtask

   task automatic step(input int c);
      logic [13:0] e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL sb_underflow cycle=%0d", c);
      end else begin
         e = sb.pop_front();
         chk($sformatf("frame_c%0d", c),
             32'({anode, digit_num, digit_dp, frame_done}),
             32'(e));
      end
   endtask

   task automatic drive_load(input logic [31:0] v,
                             input logic [7:0] dp,
                             input logic [7:0] bl,
                             input logic lz);
      ld.value       = v;
      ld.dp_mask     = dp;
      ld.blank_mask  = bl;
      ld.lz_suppress = lz;
      ld.load_valid  = 1'b1;
   endtask

   task automatic set_cur(input logic [31:0] v,
                          input logic [7:0] dp,
                          input logic [7:0] bl,
                          input logic lz);
      cur_val   = v;
      cur_dp    = dp;
      cur_blank = bl;
      cur_lz    = lz;
   endtask

   task automatic run_frame();
      push_frame(cur_val, cur_dp, cur_blank, cur_lz);
      for (int c = 0; c < FR; c++) step(c);
   endtask

   // Show the current value while loading the next one early in the frame
   task automatic frame_load(input logic [31:0] v,
                             input logic [7:0] dp,
                             input logic [7:0] bl,
                             input logic lz);
      push_frame(cur_val, cur_dp, cur_blank, cur_lz);
      for (int c = 0; c < FR; c++) begin
         step(c);
         if (c == 0) drive_load(v, dp, bl, lz);
         if (c == 1) begin
            chk("fl_ready_low", 32'(ld.load_ready), 0);
            ld.load_valid = 1'b0;
         end
      end
      set_cur(v, dp, bl, lz);
   endtask

   initial begin
      ld.load_valid  = 1'b0;
      ld.value       = '0;
      ld.dp_mask     = '0;
      ld.blank_mask  = '0;
      ld.lz_suppress = 1'b0;

      // Asynchronous reset with the clock stopped
      #2 rst_n = 1'b0;
      #2;
      chk("rst_anode", 32'(anode), 32'hFF);
      chk("rst_num", 32'(digit_num), 0);
      chk("rst_dp", 32'(digit_dp), 0);
      chk("rst_fd", 32'(frame_done), 0);
      chk("rst_ready", 32'(ld.load_ready), 1);
      clk_run = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Load while parked, then enable
      drive_load(32'h12345678, 8'h01, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      chk("park_ready_low", 32'(ld.load_ready), 0);
      ld.load_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("park_ready_high", 32'(ld.load_ready), 1);
      chk("park_anode", 32'(anode), 32'hFF);
      set_cur(32'h12345678, 8'h01, 8'h00, 1'b0);
      en = 1'b1;
      run_frame();

      // Mid-frame load plus a second request held while pending is full
      push_frame(cur_val, cur_dp, cur_blank, cur_lz);
      for (int c = 0; c < FR; c++) begin
         step(c);
         if (c == 9) drive_load(32'hDEADBEEF, 8'h00, 8'h00, 1'b0);
         if (c == 10) begin
            chk("mid_ready_low", 32'(ld.load_ready), 0);
            drive_load(32'h0BADF00D, 8'h10, 8'h00, 1'b0);
         end
         if (c == 20)
            chk("mid_ready_held", 32'(ld.load_ready), 0);
      end
      set_cur(32'hDEADBEEF, 8'h00, 8'h00, 1'b0);
      push_frame(cur_val, cur_dp, cur_blank, cur_lz);
      for (int c = 0; c < FR; c++) begin
         step(c);
         if (c == 0)
            chk("commit_ready_high", 32'(ld.load_ready), 1);
         if (c == 1) begin
            chk("second_taken", 32'(ld.load_ready), 0);
            ld.load_valid = 1'b0;
         end
      end
      set_cur(32'h0BADF00D, 8'h10, 8'h00, 1'b0);

      // Leading-zero suppression, then blanking with a DP under it
      frame_load(32'h000000F0, 8'h00, 8'h00, 1'b1);
      frame_load(32'h00000000, 8'h00, 8'h00, 1'b1);
      frame_load(32'h11111111, 8'h80, 8'h80, 1'b0);
      run_frame();

      // Drop enable during slot 3, then restart from slot 0
      push_frame(cur_val, cur_dp, cur_blank, cur_lz);
      for (int c = 0; c < 14; c++) step(c);
      en = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      chk("en_off_anode", 32'(anode), 32'hFF);
      chk("en_off_fd", 32'(frame_done), 0);
      @(posedge clk);
      #1;
      chk("en_off_anode2", 32'(anode), 32'hFF);
      en = 1'b1;
      run_frame();

      // Reset mid-frame with a load pending
      push_frame(cur_val, cur_dp, cur_blank, cur_lz);
      for (int c = 0; c < 6; c++) step(c);
      drive_load(32'hA5A5A5A5, 8'hFF, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      chk("pre_rst_ready", 32'(ld.load_ready), 0);
      ld.load_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_anode", 32'(anode), 32'hFF);
      chk("mid_rst_num", 32'(digit_num), 0);
      chk("mid_rst_dp", 32'(digit_dp), 0);
      chk("mid_rst_fd", 32'(frame_done), 0);
      chk("mid_rst_ready", 32'(ld.load_ready), 1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      set_cur(32'h0, 8'h00, 8'h00, 1'b0);
      run_frame();
      run_frame();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
